// File: rtl/nios_fprint_processor7_0_cpu7_oci_dct_packer.sv
`default_nettype none
// ============================================================================
//  Module   : nios_fprint_processor7_0_cpu7_oci_dct_packer
//  Purpose  : Producer side of the CPU7 OCI debug-capture-trace path. Packs
//             2-bit trace symbols LSB-first into a 30-bit accumulator and
//             hands full or flushed frames downstream over valid/ready. It
//             also sequences the test_ending / test_has_ended pair.
//  Ports    : clk, reset (async, active-high)
//             sym_valid/sym_data/sym_ready     - trace symbol input
//             flush                            - request to end capture
//             frame_valid/frame_ready          - output frame handshake
//             frame_data/frame_count           - packed frame, symbol count
//             dct_buffer/dct_count             - live accumulator view
//             overflow                         - sticky dropped-symbol flag
//             test_ending/test_has_ended       - capture shutdown status
//  Revision : 1.0 - initial release
// ============================================================================
module nios_fprint_processor7_0_cpu7_oci_dct_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        sym_valid,
   input  logic [1:0]  sym_data,
   output logic        sym_ready,
   input  logic        flush,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [29:0] frame_data,
   output logic [3:0]  frame_count,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        overflow,
   output logic        test_ending,
   output logic        test_has_ended
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ENDED = 2'd3
   } state_t;

   localparam logic [3:0] FULL_CNT = 4'd15;

   state_t      state_q, state_d;
   logic [29:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [29:0] frame_data_q, frame_data_d;
   logic [3:0]  frame_count_q, frame_count_d;
   logic        frame_valid_q, frame_valid_d;
   logic        overflow_q, overflow_d;
   logic        test_ending_q, test_ending_d;
   logic        test_has_ended_q, test_has_ended_d;

   logic        slot_free;
   logic        transfer;
   logic        ready_int;
   logic        accept;
   logic [29:0] acc_base;
   logic [3:0]  cnt_base;

   always_comb begin
      slot_free = !frame_valid_q || frame_ready;
      transfer  = slot_free &&
                  ((cnt_q == FULL_CNT) || ((state_q == ST_FLUSH) && (cnt_q != 4'd0)));
      // A full accumulator still takes a symbol when it empties this cycle.
      ready_int = (state_q == ST_RUN) && ((cnt_q != FULL_CNT) || transfer);
      accept    = sym_valid && ready_int;

      // Accumulator after the (optional) transfer, before the new symbol.
      acc_base  = transfer ? 30'd0 : acc_q;
      cnt_base  = transfer ? 4'd0  : cnt_q;

      acc_d = acc_base;
      cnt_d = cnt_base;
      if (accept) begin
         // Target bits are known zero, so OR-ing the shifted symbol suffices.
         acc_d = acc_base | (30'(sym_data) << {cnt_base, 1'b0});
         cnt_d = cnt_base + 4'd1;
      end

      frame_data_d  = frame_data_q;
      frame_count_d = frame_count_q;
      frame_valid_d = frame_valid_q;
      if (transfer) begin
         frame_data_d  = acc_q;
         frame_count_d = cnt_q;
         frame_valid_d = 1'b1;
      end else if (frame_valid_q && frame_ready) begin
         frame_valid_d = 1'b0;
      end

      overflow_d = overflow_q || ((state_q == ST_RUN) && sym_valid && !ready_int);

      state_d = state_q;
      case (state_q)
         ST_RUN:   if (flush) state_d = ST_FLUSH;
         // Look at the next-cycle values so the close-down follows the final
         // partial transfer / final handshake without an extra idle cycle.
         ST_FLUSH: if (cnt_d == 4'd0) state_d = ST_DRAIN;
         ST_DRAIN: if (!frame_valid_d) state_d = ST_ENDED;
         default:  state_d = ST_ENDED;
      endcase

      test_ending_d    = (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
      test_has_ended_d = (state_d == ST_ENDED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= ST_RUN;
         acc_q            <= 30'd0;
         cnt_q            <= 4'd0;
         frame_data_q     <= 30'd0;
         frame_count_q    <= 4'd0;
         frame_valid_q    <= 1'b0;
         overflow_q       <= 1'b0;
         test_ending_q    <= 1'b0;
         test_has_ended_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         acc_q            <= acc_d;
         cnt_q            <= cnt_d;
         frame_data_q     <= frame_data_d;
         frame_count_q    <= frame_count_d;
         frame_valid_q    <= frame_valid_d;
         overflow_q       <= overflow_d;
         test_ending_q    <= test_ending_d;
         test_has_ended_q <= test_has_ended_d;
      end
   end

   // sym_ready is masked by reset so every output reads zero while held.
   assign sym_ready      = ready_int && !reset;
   assign frame_valid    = frame_valid_q;
   assign frame_data     = frame_data_q;
   assign frame_count    = frame_count_q;
   assign dct_buffer     = acc_q;
   assign dct_count      = cnt_q;
   assign overflow       = overflow_q;
   assign test_ending    = test_ending_q;
   assign test_has_ended = test_has_ended_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_fprint_processor7_0_cpu7_oci_dct_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nios_fprint_processor7_0_cpu7_oci_dct_packer
//  Purpose  : Self-checking bench for the DCT packer: a vector table for the
//             single-frame fill, then directed sequences for streaming,
//             backpressure, flushing and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nios_fprint_processor7_0_cpu7_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sym_valid = 1'b0;
   logic [1:0]  sym_data = 2'd0;
   logic        sym_ready;
   logic        flush = 1'b0;
   logic        frame_valid;
   logic        frame_ready = 1'b0;
   logic [29:0] frame_data;
   logic [3:0]  frame_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        overflow;
   logic        test_ending;
   logic        test_has_ended;

   nios_fprint_processor7_0_cpu7_oci_dct_packer dut (
      .clk            (clk),
      .reset          (reset),
      .sym_valid      (sym_valid),
      .sym_data       (sym_data),
      .sym_ready      (sym_ready),
      .flush          (flush),
      .frame_valid    (frame_valid),
      .frame_ready    (frame_ready),
      .frame_data     (frame_data),
      .frame_count    (frame_count),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .overflow       (overflow),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Values sampled just before the active edge of the latest step.
   logic rdy_pre;
   logic hs_pre;

   typedef struct {
      logic        sv;
      logic [1:0]  sd;
      logic        fl;
      logic        fr;
      logic        e_rdy;
      logic [29:0] e_buf;
      logic [3:0]  e_cnt;
      logic        e_fv;
      logic [29:0] e_fd;
      logic [3:0]  e_fc;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, sample pre-edge, then wait past the edge.
   task automatic step(input logic sv, input logic [1:0] sd, input logic fl, input logic fr);
      sym_valid   = sv;
      sym_data    = sd;
      flush       = fl;
      frame_ready = fr;
      #1;
      rdy_pre = sym_ready;
      hs_pre  = frame_valid && frame_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sym_valid   = 1'b0;
      sym_data    = 2'd0;
      flush       = 1'b0;
      frame_ready = 1'b0;
      reset       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int frames;
      int ready_drops;
      logic [29:0] first_fd;
      logic [3:0]  first_fc;
      logic [31:0] mask;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("reset_sym_ready", 32'(sym_ready), 32'd0);
      chk("reset_frame_valid", 32'(frame_valid), 32'd0);
      chk("reset_dct_count", 32'(dct_count), 32'd0);
      chk("reset_dct_buffer", 32'(dct_buffer), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_test_ending", 32'(test_ending), 32'd0);
      chk("reset_test_has_ended", 32'(test_has_ended), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_reset_sym_ready", 32'(sym_ready), 32'd1);

      // ---------------- fill table ----------------
      // Symbols 3,2,1,0,... placed at [2k+1:2k] give 30'h1B1B1B1B after 15.
      for (int i = 0; i < 15; i++) begin
         mask = (32'd1 << (2 * (i + 1))) - 32'd1;
         vecs[i].sv    = 1'b1;
         vecs[i].sd    = 2'(3 - (i % 4));
         vecs[i].fl    = 1'b0;
         vecs[i].fr    = 1'b1;
         vecs[i].e_rdy = 1'b1;
         vecs[i].e_buf = 30'(32'h1B1B1B1B & mask);
         vecs[i].e_cnt = 4'(i + 1);
         vecs[i].e_fv  = 1'b0;
         vecs[i].e_fd  = 30'd0;
         vecs[i].e_fc  = 4'd0;
      end
      vecs[15] = '{sv:1'b0, sd:2'd0, fl:1'b0, fr:1'b1, e_rdy:1'b1, e_buf:30'd0,
                   e_cnt:4'd0, e_fv:1'b1, e_fd:30'h1B1B1B1B, e_fc:4'd15};
      vecs[16] = '{sv:1'b0, sd:2'd0, fl:1'b0, fr:1'b1, e_rdy:1'b1, e_buf:30'd0,
                   e_cnt:4'd0, e_fv:1'b0, e_fd:30'd0, e_fc:4'd0};

      for (int i = 0; i < 17; i++) begin
         step(vecs[i].sv, vecs[i].sd, vecs[i].fl, vecs[i].fr);
         chk($sformatf("fill[%0d]_sym_ready", i), 32'(rdy_pre), 32'(vecs[i].e_rdy));
         chk($sformatf("fill[%0d]_dct_buffer", i), 32'(dct_buffer), 32'(vecs[i].e_buf));
         chk($sformatf("fill[%0d]_dct_count", i), 32'(dct_count), 32'(vecs[i].e_cnt));
         chk($sformatf("fill[%0d]_frame_valid", i), 32'(frame_valid), 32'(vecs[i].e_fv));
         if (vecs[i].e_fv) begin
            chk($sformatf("fill[%0d]_frame_data", i), 32'(frame_data), 32'(vecs[i].e_fd));
            chk($sformatf("fill[%0d]_frame_count", i), 32'(frame_count), 32'(vecs[i].e_fc));
         end
         chk($sformatf("fill[%0d]_overflow", i), 32'(overflow), 32'd0);
      end

      // ---------------- stream: 45 symbols 0,1,2,3,... ----------------
      do_reset();
      frames = 0;
      ready_drops = 0;
      first_fd = 30'd0;
      first_fc = 4'd0;
      for (int i = 0; i < 50; i++) begin
         if (frame_valid && frames == 0) begin
            first_fd = frame_data;
            first_fc = frame_count;
         end
         step(i < 45, 2'(i % 4), 1'b0, 1'b1);
         if (i < 45 && !rdy_pre) ready_drops++;
         if (hs_pre) frames++;
      end
      chk("stream_frames", 32'(frames), 32'd3);
      chk("stream_ready_drops", 32'(ready_drops), 32'd0);
      chk("stream_overflow", 32'(overflow), 32'd0);
      chk("stream_first_frame_data", 32'(first_fd), 32'h24E4E4E4);
      chk("stream_first_frame_count", 32'(first_fc), 32'd15);
      chk("stream_dct_count_idle", 32'(dct_count), 32'd0);

      // ---------------- backpressure ----------------
      do_reset();
      ready_drops = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, (i < 15) ? 2'd1 : 2'd2, 1'b0, 1'b0);
         if (!rdy_pre) ready_drops++;
      end
      chk("bp_no_early_drop", 32'(ready_drops), 32'd0);
      chk("bp_overflow_before", 32'(overflow), 32'd0);
      step(1'b1, 2'd3, 1'b0, 1'b0);
      chk("bp_sym31_ready", 32'(rdy_pre), 32'd0);
      chk("bp_overflow_set", 32'(overflow), 32'd1);
      chk("bp_frame1_valid", 32'(frame_valid), 32'd1);
      chk("bp_frame1_data", 32'(frame_data), 32'h15555555);
      chk("bp_acc_full_count", 32'(dct_count), 32'd15);
      chk("bp_acc_full_buf", 32'(dct_buffer), 32'h2AAAAAAA);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("bp_release1_hs", 32'(hs_pre), 32'd1);
      chk("bp_frame2_valid", 32'(frame_valid), 32'd1);
      chk("bp_frame2_data", 32'(frame_data), 32'h2AAAAAAA);
      chk("bp_frame2_count", 32'(frame_count), 32'd15);
      chk("bp_acc_empty", 32'(dct_count), 32'd0);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("bp_release2_hs", 32'(hs_pre), 32'd1);
      chk("bp_all_released", 32'(frame_valid), 32'd0);
      chk("bp_overflow_sticky", 32'(overflow), 32'd1);

      // ---------------- partial flush ----------------
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 1'b0, 1'b1);
      chk("pf_dct_buffer", 32'(dct_buffer), 32'h000000FF);
      step(1'b0, 2'd0, 1'b1, 1'b1);
      chk("pf_ending_rise", 32'(test_ending), 32'd1);
      chk("pf_no_frame_yet", 32'(frame_valid), 32'd0);
      step(1'b1, 2'd1, 1'b0, 1'b1);
      chk("pf_flush_sym_ready", 32'(rdy_pre), 32'd0);
      chk("pf_frame_valid", 32'(frame_valid), 32'd1);
      chk("pf_frame_data", 32'(frame_data), 32'h000000FF);
      chk("pf_frame_count", 32'(frame_count), 32'd4);
      chk("pf_ending_held", 32'(test_ending), 32'd1);
      chk("pf_not_ended", 32'(test_has_ended), 32'd0);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("pf_final_hs", 32'(hs_pre), 32'd1);
      chk("pf_ended", 32'(test_has_ended), 32'd1);
      chk("pf_ending_fall", 32'(test_ending), 32'd0);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("pf_ended_sticky", 32'(test_has_ended), 32'd1);
      chk("pf_overflow", 32'(overflow), 32'd0);

      // ---------------- empty flush, then ignore ----------------
      do_reset();
      step(1'b0, 2'd0, 1'b1, 1'b1);
      chk("ef_ending_rise", 32'(test_ending), 32'd1);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("ef_not_ended_yet", 32'(test_has_ended), 32'd0);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("ef_ended", 32'(test_has_ended), 32'd1);
      chk("ef_ending_fall", 32'(test_ending), 32'd0);
      chk("ef_no_frame", 32'(frame_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'd2, 1'b1, 1'b1);
         chk($sformatf("ef_ignore[%0d]_ready", i), 32'(rdy_pre), 32'd0);
      end
      chk("ef_ignore_count", 32'(dct_count), 32'd0);
      chk("ef_ignore_overflow", 32'(overflow), 32'd0);
      chk("ef_ignore_ended", 32'(test_has_ended), 32'd1);

      // ---------------- reset mid-flush (in DRAIN) ----------------
      do_reset();
      step(1'b1, 2'd1, 1'b0, 1'b0);
      step(1'b1, 2'd2, 1'b1, 1'b0);
      chk("rf_flush_cycle_accept", 32'(rdy_pre), 32'd1);
      chk("rf_flush_cycle_count", 32'(dct_count), 32'd2);
      step(1'b0, 2'd0, 1'b0, 1'b0);
      chk("rf_frame_held", 32'(frame_valid), 32'd1);
      chk("rf_frame_data", 32'(frame_data), 32'h00000009);
      chk("rf_draining", 32'(test_ending), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rf_async_frame_valid", 32'(frame_valid), 32'd0);
      chk("rf_async_frame_data", 32'(frame_data), 32'd0);
      chk("rf_async_test_ending", 32'(test_ending), 32'd0);
      chk("rf_async_sym_ready", 32'(sym_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 2'd0, 1'b0, 1'b0);
      chk("rf_run_sym_ready", 32'(rdy_pre), 32'd1);
      chk("rf_run_not_ending", 32'(test_ending), 32'd0);
      chk("rf_run_not_ended", 32'(test_has_ended), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
